// File: rtl/ctrl_pkg.sv
// ctrl_pkg: types and constants shared by the multicycle control FSM and the
// opcode classifier. It holds the state enumeration, the opcode values and
// classes, the alu_op encodings and the registered control-word layout.
// Configuration: defining MULTICYCLE_ILLEGAL_TRAP_EN adds the HALT state.
package ctrl_pkg;

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned ALUOP_W = 3;

  // Opcode values recognised by the decoder.
  localparam logic [OPC_W-1:0] OPC_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_I      = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

  // ALU operation encodings.
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b001;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 3'b010;
  localparam logic [ALUOP_W-1:0] ALUOP_IMMF  = 3'b011;

  typedef enum logic [2:0] {
    OPCLS_R       = 3'd0,
    OPCLS_I       = 3'd1,
    OPCLS_LOAD    = 3'd2,
    OPCLS_STORE   = 3'd3,
    OPCLS_BRANCH  = 3'd4,
    OPCLS_ILLEGAL = 3'd5
  } opclass_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    ,
    ST_HALT   = 3'd6
`endif
  } state_e;

  // Registered datapath control word.
  typedef struct packed {
    logic               mem_req;
    logic               mem_rd;
    logic               mem_wr;
    logic               ir_wr;
    logic               pc_wr;
    logic               branch;
    logic               mem_to_reg;
    logic               alu_src;
    logic               reg_wr;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  // ALU operation used in EXEC for a given instruction class.
  function automatic logic [ALUOP_W-1:0] alu_op_for(input opclass_e cls);
    logic [ALUOP_W-1:0] op;
    op = ALUOP_ADD;
    case (cls)
      OPCLS_R:      op = ALUOP_FUNCT;
      OPCLS_I:      op = ALUOP_IMMF;
      OPCLS_BRANCH: op = ALUOP_SUB;
      default:      op = ALUOP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/opcode_classifier.sv
// opcode_classifier: purely combinational opcode-to-class decoder, shared by
// the multicycle and single-cycle control units.
// Ports:
//   opcode_i   in   instruction opcode field
//   opclass_o  out  instruction class; anything unrecognised is ILLEGAL
module opcode_classifier
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODELEN = 7
) (
  input  logic [OPCODELEN-1:0] opcode_i,
  output opclass_e             opclass_o
);

  always_comb begin
    opclass_o = OPCLS_ILLEGAL;
    case (opcode_i)
      OPCODELEN'(OPC_R):      opclass_o = OPCLS_R;
      OPCODELEN'(OPC_I):      opclass_o = OPCLS_I;
      OPCODELEN'(OPC_LOAD):   opclass_o = OPCLS_LOAD;
      OPCODELEN'(OPC_STORE):  opclass_o = OPCLS_STORE;
      OPCODELEN'(OPC_BRANCH): opclass_o = OPCLS_BRANCH;
      default:                opclass_o = OPCLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: control unit for a multicycle processor. Walks
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) per instruction and drives
// registered datapath/memory controls from the state and the latched opcode.
// Configuration: define MULTICYCLE_ILLEGAL_TRAP_EN to trap illegal opcodes in
// a HALT state (left only by rst); otherwise they retire as NOPs.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   opcode              opcode field of the instruction register
//   mem_ready           memory completes the current access this cycle
//   mem_req/mem_rd/mem_wr  memory request and direction strobes
//   ir_wr, pc_wr        instruction register load, PC+4 load
//   branch, mem_to_reg, alu_src, reg_wr, alu_op  datapath controls
//   illegal             one-cycle pulse for an unrecognised opcode
//   instr_cnt           retired-instruction count (wraps)
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODELEN = 7,
  parameter int unsigned ALUOPLEN  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPCODELEN-1:0] opcode,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic                 ir_wr,
  output logic                 pc_wr,
  output logic                 branch,
  output logic                 mem_to_reg,
  output logic                 alu_src,
  output logic                 reg_wr,
  output logic [ALUOPLEN-1:0]  alu_op,
  output logic                 illegal,
  output logic [15:0]          instr_cnt
);

  localparam int unsigned CNT_W = 16;

  state_e               state_q, state_d;
  logic [OPCODELEN-1:0] opcode_q, opcode_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  ctrl_t                ctrl_q, ctrl_d;
  logic                 illegal_q, illegal_d;
  opclass_e             cls;

  // The opcode input only matters in DECODE; everywhere else the latched copy is used.
  assign opcode_d = (state_q == ST_DECODE) ? opcode : opcode_q;

  opcode_classifier #(
    .OPCODELEN (OPCODELEN)
  ) u_classifier (
    .opcode_i  (opcode_d),
    .opclass_o (cls)
  );

  // Next state, retire counter and illegal pulse.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (cls == OPCLS_ILLEGAL) begin
          illegal_d = 1'b1;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          state_d   = ST_HALT;
`else
          state_d   = ST_FETCH;
          cnt_d     = cnt_q + CNT_W'(1);
`endif
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls)
          OPCLS_R, OPCLS_I:         state_d = ST_WB;
          OPCLS_LOAD, OPCLS_STORE:  state_d = ST_MEM;
          default: begin
            // BRANCH completes here; ILLEGAL never reaches EXEC.
            state_d = ST_FETCH;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (cls == OPCLS_LOAD) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_FETCH;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        cnt_d   = cnt_q + CNT_W'(1);
      end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      ST_HALT: state_d = ST_HALT;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Control word for the state being entered, so the registered outputs line
  // up with the state register without any combinational path from mem_ready.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      ST_FETCH: begin
        ctrl_d.mem_req = 1'b1;
        ctrl_d.mem_rd  = 1'b1;
      end
      ST_DECODE: begin
        // One-cycle load strobes accompanying the accepted fetch.
        ctrl_d.ir_wr = 1'b1;
        ctrl_d.pc_wr = 1'b1;
      end
      ST_EXEC: begin
        ctrl_d.alu_op  = alu_op_for(cls);
        ctrl_d.alu_src = (cls == OPCLS_I) || (cls == OPCLS_LOAD) || (cls == OPCLS_STORE);
        ctrl_d.branch  = (cls == OPCLS_BRANCH);
      end
      ST_MEM: begin
        ctrl_d.mem_req = 1'b1;
        ctrl_d.mem_rd  = (cls == OPCLS_LOAD);
        ctrl_d.mem_wr  = (cls == OPCLS_STORE);
      end
      ST_WB: begin
        ctrl_d.reg_wr     = 1'b1;
        ctrl_d.mem_to_reg = (cls == OPCLS_LOAD);
      end
      default: ctrl_d = '0;
    endcase
  end

  // State, latched opcode, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      opcode_q  <= '0;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  assign mem_req    = ctrl_q.mem_req;
  assign mem_rd     = ctrl_q.mem_rd;
  assign mem_wr     = ctrl_q.mem_wr;
  assign ir_wr      = ctrl_q.ir_wr;
  assign pc_wr      = ctrl_q.pc_wr;
  assign branch     = ctrl_q.branch;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign alu_src    = ctrl_q.alu_src;
  assign reg_wr     = ctrl_q.reg_wr;
  assign alu_op     = ALUOPLEN'(ctrl_q.alu_op);
  assign illegal    = illegal_q;
  assign instr_cnt  = cnt_q;

endmodule
